// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm-compare datapath / board I/O and alarm_sequencer.
// master drives the requests and strobes; slave (the sequencer) drives the speaker, LED and status.
interface alarm_sequencer_if;
    logic       tick_1hz;
    logic       alarm_match;
    logic       alarm_on;
    logic       stop_req;
    logic       snooze_req;
    logic       sound;
    logic       alarm_led;
    logic [1:0] state;
    logic [1:0] snooze_cnt;

    modport master (
        output tick_1hz, alarm_match, alarm_on, stop_req, snooze_req,
        input  sound, alarm_led, state, snooze_cnt
    );

    modport slave (
        input  tick_1hz, alarm_match, alarm_on, stop_req, snooze_req,
        output sound, alarm_led, state, snooze_cnt
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Ring / snooze / cancel sequencer for the 24-hour clock alarm, with speaker tone generation.
// Define ALARM_SNOOZE_EN to build in the snooze feature; without it a ring always ends in IDLE.
module alarm_sequencer #(
    parameter int TONE_DIV    = 50000,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    alarm_sequencer_if.slave   bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;

    localparam int             TONE_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [8:0]     RING_LAST = 9'(RING_SECS - 1);

    if (MAX_SNOOZE < 1 || MAX_SNOOZE > 3 || SNOOZE_SECS < 1 || SNOOZE_SECS > 512 ||
        RING_SECS < 1 || RING_SECS > 512 || TONE_DIV < 1) begin : g_param_check
        $error("alarm_sequencer: parameter out of range");
    end

    logic [1:0]        state_q, state_n;
    logic [8:0]        sec_cnt;
    logic              match_d;
    logic              beep;
    logic [TONE_W-1:0] tone_cnt;
    logic              tone_q;
    logic              trigger;
    logic              timeout;

    assign trigger = bus.alarm_match & ~match_d & bus.alarm_on;
    assign timeout = bus.tick_1hz && (sec_cnt == RING_LAST);

`ifdef ALARM_SNOOZE_EN
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    logic [1:0] snooze_cnt_q, snooze_cnt_n;
    logic       can_snooze;

    assign can_snooze = snooze_cnt_q < SNOOZE_MAX;

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n      = state_q;
        snooze_cnt_n = snooze_cnt_q;
        case (state_q)
            IDLE: if (trigger) begin
                state_n      = RINGING;
                snooze_cnt_n = 2'd0;
            end
            RINGING: begin
                if (!bus.alarm_on || bus.stop_req) begin
                    state_n = IDLE;
                end else if ((bus.snooze_req || timeout) && can_snooze) begin
                    // A snooze press coinciding with the timeout tick is one snooze, not two.
                    state_n      = SNOOZE;
                    snooze_cnt_n = snooze_cnt_q + 2'd1;
                end else if (timeout) begin
                    state_n = IDLE;
                end
            end
            SNOOZE: begin
                if (!bus.alarm_on || bus.stop_req) begin
                    state_n = IDLE;
                end else if (bus.tick_1hz && sec_cnt == SNOOZE_LAST) begin
                    state_n = RINGING;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snooze_cnt_q   <= 2'd0;
            bus.snooze_cnt <= 2'd0;
        end else begin
            snooze_cnt_q   <= snooze_cnt_n;
            bus.snooze_cnt <= snooze_cnt_q;
        end
    end
`else
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (trigger) state_n = RINGING;
            RINGING: if (!bus.alarm_on || bus.stop_req || timeout) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.snooze_cnt = 2'd0;
`endif

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            match_d       <= 1'b0;
            sec_cnt       <= 9'd0;
            beep          <= 1'b0;
            tone_cnt      <= '0;
            tone_q        <= 1'b0;
            bus.sound     <= 1'b0;
            bus.state     <= IDLE;
            bus.alarm_led <= 1'b0;
        end else begin
            state_q <= state_n;
            match_d <= bus.alarm_match;

            if (state_n != state_q) begin
                sec_cnt <= 9'd0;
            end else if (bus.tick_1hz && state_q != IDLE) begin
                sec_cnt <= sec_cnt + 9'd1;
            end

            // Beep gate: on at ring entry, flips each second while ringing, off elsewhere.
            if (state_n != RINGING) begin
                beep <= 1'b0;
            end else if (state_q != RINGING) begin
                beep <= 1'b1;
            end else if (bus.tick_1hz) begin
                beep <= ~beep;
            end

            if (!beep) begin
                tone_cnt <= '0;
                tone_q   <= 1'b0;
            end else if (tone_cnt == TONE_LAST) begin
                tone_cnt <= '0;
                tone_q   <= ~tone_q;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end

            bus.sound     <= tone_q;
            bus.state     <= state_q;
            bus.alarm_led <= (state_q != IDLE);
        end
    end
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer; expectations follow whether ALARM_SNOOZE_EN is defined.
module tb_alarm_sequencer;
    localparam int TONE_DIV    = 4;
    localparam int RING_SECS   = 5;
    localparam int SNOOZE_SECS = 3;
    localparam int MAX_SNOOZE  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .TONE_DIV   (TONE_DIV),
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One second of idle time ending with a tick edge; returns at the negedge after that edge.
    task automatic second();
        cyc(19);
        bus.tick_1hz = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
    endtask

    task automatic seconds(input int n);
        repeat (n) second();
    endtask

    // Fresh rising match edge; returns one edge after entry so state output reads RINGING.
    task automatic ring_up();
        bus.alarm_match = 1'b0;
        cyc(2);
        bus.alarm_match = 1'b1;
        cyc(2);
    endtask

    task automatic pulse_stop();
        bus.stop_req = 1'b1;
        cyc(1);
        bus.stop_req = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.snooze_req = 1'b1;
        cyc(1);
        bus.snooze_req = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL reset_sound: got %0b expected 0", bus.sound); end
        n_checks++; if (bus.alarm_led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %0b expected 0", bus.alarm_led); end
        n_checks++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_snooze_cnt: got %0d expected 0", bus.snooze_cnt); end
        reset_n = 1'b1;
        cyc(3);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL post_reset_idle: got %0d expected 0", bus.state); end
    endtask

    task automatic test_trigger_stop();
        int bad;
        bus.alarm_on = 1'b0;
        bus.alarm_match = 1'b1;
        cyc(3);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL trig_disabled: got %0d expected 0", bus.state); end
        bus.alarm_on = 1'b1;
        cyc(3);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL trig_no_edge: got %0d expected 0", bus.state); end
        bus.alarm_match = 1'b0;
        cyc(2);
        bus.alarm_match = 1'b1;
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL trig_latency: got %0d expected 0", bus.state); end
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL trig_state: got %0d expected 1", bus.state); end
        n_checks++; if (bus.alarm_led !== 1'b1) begin n_fail++; $display("FAIL trig_led: got %0b expected 1", bus.alarm_led); end
        cyc(3);
        n_checks++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL tone_before_rise: got %0b expected 0", bus.sound); end
        cyc(1);
        n_checks++; if (bus.sound !== 1'b1) begin n_fail++; $display("FAIL tone_first_rise: got %0b expected 1", bus.sound); end
        cyc(4);
        n_checks++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL tone_first_fall: got %0b expected 0", bus.sound); end
        second();
        cyc(2);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.sound !== 1'b0) bad++;
            cyc(1);
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL beep_off_silent: got %0d high samples expected 0", bad); end
        second();
        cyc(4);
        n_checks++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL beep_on_before_rise: got %0b expected 0", bus.sound); end
        cyc(1);
        n_checks++; if (bus.sound !== 1'b1) begin n_fail++; $display("FAIL beep_on_rise: got %0b expected 1", bus.sound); end
        pulse_stop();
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL stop_latency: got %0d expected 1", bus.state); end
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL stop_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.alarm_led !== 1'b0) begin n_fail++; $display("FAIL stop_led: got %0b expected 0", bus.alarm_led); end
        cyc(1);
        n_checks++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL stop_sound: got %0b expected 0", bus.sound); end
        cyc(30);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL no_retrigger: got %0d expected 0", bus.state); end
        bus.alarm_match = 1'b0;
        cyc(2);
    endtask

`ifdef ALARM_SNOOZE_EN
    task automatic test_snooze_cycle();
        ring_up();
        pulse_snooze();
        cyc(1);
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL snz1_state: got %0d expected 2", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL snz1_cnt: got %0d expected 1", bus.snooze_cnt); end
        seconds(2);
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL snz1_hold: got %0d expected 2", bus.state); end
        second();
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL snz1_rering: got %0d expected 1", bus.state); end
        pulse_snooze();
        cyc(1);
        n_checks++; if (bus.snooze_cnt !== 2'd2) begin n_fail++; $display("FAIL snz2_cnt: got %0d expected 2", bus.snooze_cnt); end
        seconds(3);
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL snz2_rering: got %0d expected 1", bus.state); end
        pulse_snooze();
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL snz3_ignored: got %0d expected 1", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd2) begin n_fail++; $display("FAIL snz3_cnt: got %0d expected 2", bus.snooze_cnt); end
        seconds(4);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL snz_final_ring: got %0d expected 1", bus.state); end
        second();
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL snz_final_idle: got %0d expected 0", bus.state); end
    endtask
`else
    task automatic test_snooze_ignored();
        ring_up();
        pulse_snooze();
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL nosnz_state: got %0d expected 1", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL nosnz_cnt: got %0d expected 0", bus.snooze_cnt); end
        pulse_stop();
        cyc(1);
    endtask
`endif

    task automatic test_timeout();
        ring_up();
        seconds(4);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL to_before: got %0d expected 1", bus.state); end
        second();
        cyc(1);
`ifdef ALARM_SNOOZE_EN
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL to1_state: got %0d expected 2", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL to1_cnt: got %0d expected 1", bus.snooze_cnt); end
        seconds(3);
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL to1_rering: got %0d expected 1", bus.state); end
        seconds(5);
        cyc(1);
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL to2_state: got %0d expected 2", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd2) begin n_fail++; $display("FAIL to2_cnt: got %0d expected 2", bus.snooze_cnt); end
        seconds(3);
        cyc(1);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL to2_rering: got %0d expected 1", bus.state); end
        seconds(5);
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL to_final_idle: got %0d expected 0", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd2) begin n_fail++; $display("FAIL to_final_cnt: got %0d expected 2", bus.snooze_cnt); end
`else
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL to_idle: got %0d expected 0", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL to_cnt: got %0d expected 0", bus.snooze_cnt); end
`endif
    endtask

    task automatic test_priorities();
`ifdef ALARM_SNOOZE_EN
        ring_up();
        pulse_snooze();
        seconds(3);
        cyc(1);
        bus.stop_req = 1'b1;
        bus.snooze_req = 1'b1;
        cyc(1);
        bus.stop_req = 1'b0;
        bus.snooze_req = 1'b0;
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL prio_stop_snz_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL prio_stop_snz_cnt: got %0d expected 1", bus.snooze_cnt); end

        ring_up();
        seconds(4);
        cyc(19);
        bus.tick_1hz = 1'b1;
        bus.snooze_req = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
        bus.snooze_req = 1'b0;
        cyc(1);
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL prio_snz_to_state: got %0d expected 2", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd1) begin n_fail++; $display("FAIL prio_snz_to_cnt: got %0d expected 1", bus.snooze_cnt); end
        pulse_stop();
        cyc(1);
`endif
        ring_up();
        seconds(4);
        cyc(19);
        bus.tick_1hz = 1'b1;
        bus.stop_req = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
        bus.stop_req = 1'b0;
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL prio_stop_to_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.snooze_cnt !== 2'd0) begin n_fail++; $display("FAIL prio_stop_to_cnt: got %0d expected 0", bus.snooze_cnt); end
    endtask

    task automatic test_disable_reset();
        ring_up();
`ifdef ALARM_SNOOZE_EN
        pulse_snooze();
        cyc(1);
        n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL dis_setup: got %0d expected 2", bus.state); end
`endif
        bus.alarm_on = 1'b0;
        cyc(1);
        n_checks++; if (bus.state === 2'd0) begin n_fail++; $display("FAIL dis_latency: got %0d expected nonzero", bus.state); end
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL dis_state: got %0d expected 0", bus.state); end
        bus.alarm_on = 1'b1;

        ring_up();
        cyc(4);
        n_checks++; if (bus.sound !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sound: got %0b expected 1", bus.sound); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.sound !== 1'b0) begin n_fail++; $display("FAIL rst_async_sound: got %0b expected 0", bus.sound); end
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_async_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.alarm_led !== 1'b0) begin n_fail++; $display("FAIL rst_async_led: got %0b expected 0", bus.alarm_led); end
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);
        n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL rst_match_high: got %0d expected 1", bus.state); end
        pulse_stop();
        cyc(1);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_final_stop: got %0d expected 0", bus.state); end
        bus.alarm_match = 1'b0;
    endtask

    initial begin
        bus.tick_1hz    = 1'b0;
        bus.alarm_match = 1'b0;
        bus.alarm_on    = 1'b0;
        bus.stop_req    = 1'b0;
        bus.snooze_req  = 1'b0;
        reset_n         = 1'b0;
        cyc(2);
        test_reset();
        test_trigger_stop();
`ifdef ALARM_SNOOZE_EN
        test_snooze_cycle();
`else
        test_snooze_ignored();
`endif
        test_timeout();
        test_priorities();
        test_disable_reset();
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequences the alarm output of the 24-hour clock. Takes a level "current time equals alarm time" flag, the alarm-enable switch, debounced stop/snooze pulses and a 1 Hz strobe. Runs the ring / snooze / cancel state machine and drives the speaker tone, the alarm LED and status. Sits between the timekeeping/alarm-compare datapath and the board I/O, replacing direct drive of `sound`.

## Interface

- `TONE_DIV`, 50000: clk cycles per tone half-period (1 kHz at 100 MHz).
- `RING_SECS`, 60: ticks of continuous ringing before auto-timeout.
- `SNOOZE_SECS`, 300: ticks spent silent in snooze before re-ringing.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event (1..3).

- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `tick_1hz` input 1: one-cycle strobe, once per second.
- `alarm_match` input 1: level, high while HH:MM equals the stored alarm.
- `alarm_on` input 1: alarm-enable switch, level.
- `stop_req` input 1: one-cycle pulse, debounced stop button.
- `snooze_req` input 1: one-cycle pulse, debounced snooze button.
- `sound` output 1: speaker square wave.
- `alarm_led` output 1: high in RINGING or SNOOZE.
- `state` output 2: 0 IDLE, 1 RINGING, 2 SNOOZE.
- `snooze_cnt` output 2: snoozes used in the current event.

## Operation

- `match_d` is a register holding `alarm_match` from the previous cycle. `trigger` = `alarm_match & ~match_d & alarm_on`.
- `sec_cnt` is the per-state tick counter, 9 bits. It is cleared on every state entry and increments on `tick_1hz` in RINGING and SNOOZE.
- **IDLE**:
  - `trigger` moves the state to RINGING and clears `snooze_cnt`.
- **RINGING**: transition priority, highest first:
  - `alarm_on`=0: go to IDLE.
  - `stop_req`: go to IDLE.
  - `snooze_req` with `snooze_cnt` < `MAX_SNOOZE`: go to SNOOZE and increment `snooze_cnt`. With `snooze_cnt` = `MAX_SNOOZE`, `snooze_req` is ignored.
  - `tick_1hz` with `sec_cnt` = `RING_SECS`-1 (timeout): go to SNOOZE and increment `snooze_cnt` if `snooze_cnt` < `MAX_SNOOZE`. Otherwise go to IDLE.
- **SNOOZE**: transition priority, highest first:
  - `alarm_on`=0: go to IDLE.
  - `stop_req`: go to IDLE.
  - `tick_1hz` with `sec_cnt` = `SNOOZE_SECS`-1: go to RINGING.
  - `snooze_req` is ignored.
- `trigger` is ignored outside IDLE. A new match edge never restarts an active event.
- **Beep gate `beep`**:
  - Set to 1 on entry to RINGING.
  - Toggles on each `tick_1hz` while in RINGING, giving 1 s on / 1 s off.
  - Held at 0 in other states.
- **Tone**:
  - `tone_cnt` counts 0..`TONE_DIV`-1 while `beep`=1. On wrap it toggles `tone_q`.
  - When `beep`=0, both `tone_cnt` and `tone_q` are cleared.
  - `sound` = `tone_q`, registered.
- Outputs `alarm_led`, `state` and `snooze_cnt` are registered directly from state flops.

## Timing

- Reset values: state IDLE, `sound` 0, `alarm_led` 0, `state` 0, `snooze_cnt` 0, `match_d` 0, `beep` 0, all counters 0.
- Reset is asynchronous. Asserting `reset_n` mid-ring silences `sound` immediately, with no clock needed.
- **Match edge**:
  - If `alarm_match` is already high when reset is released, it counts as a rising edge on the first clock.
- **Trigger latency**:
  - `alarm_match` is first sampled high at edge N.
  - `state`=RINGING and `alarm_led`=1 after edge N+1.
  - The first `sound` rise follows `TONE_DIV` cycles later.
- **Stop/snooze latency**: pulse sampled at edge N, new state after edge N+1, `sound` 0 after edge N+2.
- **Simultaneous events**:
  - `stop_req` and `snooze_req` together: stop wins.
  - `stop_req` together with a timeout tick: stop wins.
  - `snooze_req` together with a timeout tick: a single snooze is taken and `snooze_cnt` increments once.
- `alarm_on` falling has the same latency as stop.

## Configuration

- Macro: `ALARM_SNOOZE_EN`.
- **Defined**: behaviour as above.
- **Undefined**:
  - `snooze_req` is ignored.
  - SNOOZE is unreachable.
  - RINGING timeout goes to IDLE.
  - `snooze_cnt` is tied to 0.
  - `MAX_SNOOZE` and `SNOOZE_SECS` are unused.

## Test plan

Bench parameters: `TONE_DIV`=4, `RING_SECS`=5, `SNOOZE_SECS`=3, `MAX_SNOOZE`=2, tick every 20 clk.

- **Trigger and stop**:
  - Stimulus: `alarm_on`=1, raise `alarm_match`.
  - Response: `state`=1 one cycle later; `sound` toggles every 4 clk during beep-on seconds and is 0 during beep-off seconds.
  - Then pulse `stop_req`: `state`=0 next cycle, `sound`=0 the cycle after.
  - Hold `alarm_match` high: no retrigger.
- **Snooze cycle**:
  - Ring, then pulse `snooze_req`: `state`=2, `snooze_cnt`=1.
  - After 3 ticks: `state`=1.
  - Snooze again: `snooze_cnt`=2.
  - Third `snooze_req` during ringing is ignored.
  - After 5 ticks: `state`=0.
- **Auto-timeout**:
  - Ring with no input: after 5 ticks `state`=2 and `snooze_cnt`=1.
  - Repeat: after the second timeout the cycle ends with `state`=0.
- **Priorities**: `stop_req` and `snooze_req` in the same cycle gives `state`=0 and `snooze_cnt` unchanged.
- **Disable and reset**:
  - Drop `alarm_on` in SNOOZE: `state`=0 next cycle.
  - Assert `reset_n`=0 asynchronously mid-ring: `sound`=0 and `state`=0 with no clock edge.
- **Macro off**:
  - Build without `ALARM_SNOOZE_EN`: `snooze_req` has no effect.
  - Timeout after 5 ticks gives `state`=0.
  - `snooze_cnt` stays 0 throughout.
